// File: rtl/sar_pwm_dac.sv
// sar_pwm_dac
// SAR analog back end. Takes an 8-bit trial code, drives it out as a PWM
// waveform for an external RC-filtered DAC, waits SETTLE_PERIODS full PWM
// periods for the filter to settle, then takes three synchronized comparator
// samples and returns their majority as a one-bit decision.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   code_in     8-bit trial code from the SAR controller
//   code_valid  trial code offered
//   code_ready  block can accept a code (IDLE, not in reset)
//   comp_in     raw external comparator output, asynchronous to clk
//   pwm_out     registered PWM drive to the RC filter
//   comp_out    decision for the last accepted code, held until the next one
//   comp_valid  one-cycle pulse marking a new comp_out
//   busy        high while settling or sampling
module sar_pwm_dac #(
    parameter int SETTLE_PERIODS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    input  logic       comp_in,
    output logic       pwm_out,
    output logic       comp_out,
    output logic       comp_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_PERIOD_C = 4'(SETTLE_PERIODS - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] code_r;
    logic [7:0] pwm_cnt_r;
    logic [3:0] period_r;
    logic [1:0] samp_cnt_r;
    logic [1:0] samp_r;
    logic       sync1_r;
    logic       sync2_r;
    logic       pwm_r;
    logic       comp_out_r;
    logic       comp_valid_r;
    logic       busy_r;
    logic       ready_r;
    logic       accept_s;
    logic       settle_done_s;
    logic       sample_done_s;

    // Majority vote of three comparator samples rejects a single-cycle glitch.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // ready_r mirrors "state is IDLE"; rst gates it so nothing is offered in reset.
    assign code_ready    = ready_r & ~rst;
    assign accept_s      = code_valid & ready_r;
    assign settle_done_s = (state_r == ST_SETTLE) && (period_r == LAST_PERIOD_C) &&
                           (pwm_cnt_r == 8'hFF);
    assign sample_done_s = (state_r == ST_SAMPLE) && (samp_cnt_r == 2'd2);

    assign pwm_out    = pwm_r;
    assign comp_out   = comp_out_r;
    assign comp_valid = comp_valid_r;
    assign busy       = busy_r;

    // Next-state logic for the IDLE -> SETTLE -> SAMPLE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_SETTLE;
                else          state_nxt_s = ST_IDLE;
            end
            ST_SETTLE: begin
                if (settle_done_s) state_nxt_s = ST_SAMPLE;
                else               state_nxt_s = ST_SETTLE;
            end
            ST_SAMPLE: begin
                if (sample_done_s) state_nxt_s = ST_IDLE;
                else               state_nxt_s = ST_SAMPLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus the registered busy/ready decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Code latch on handshake; the held code keeps driving PWM while idle.
    always_ff @(posedge clk) begin
        if (rst)           code_r <= 8'h00;
        else if (accept_s) code_r <= code_in;
        else               code_r <= code_r;
    end

    // Free-running PWM counter, restarted so each trial begins a fresh period.
    always_ff @(posedge clk) begin
        if (rst)           pwm_cnt_r <= 8'h00;
        else if (accept_s) pwm_cnt_r <= 8'h00;
        else               pwm_cnt_r <= pwm_cnt_r + 8'd1;
    end

    // Settling period counter, advanced on each PWM wrap during SETTLE.
    always_ff @(posedge clk) begin
        if (rst)                                             period_r <= 4'd0;
        else if (accept_s)                                   period_r <= 4'd0;
        else if ((state_r == ST_SETTLE) && (pwm_cnt_r == 8'hFF)) period_r <= period_r + 4'd1;
        else                                                 period_r <= period_r;
    end

    // Registered PWM compare: duty is code/256, 0x00 never high.
    always_ff @(posedge clk) begin
        if (rst) pwm_r <= 1'b0;
        else     pwm_r <= (pwm_cnt_r < code_r);
    end

    // Two-flop synchronizer for the asynchronous comparator input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= comp_in;
            sync2_r <= sync1_r;
        end
    end

    // Capture the first two samples; the third is taken directly at the vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt_r <= 2'd0;
            samp_r     <= 2'b00;
        end else if ((state_r == ST_SAMPLE) && !sample_done_s) begin
            samp_cnt_r <= samp_cnt_r + 2'd1;
            case (samp_cnt_r)
                2'd0:    samp_r[0] <= sync2_r;
                2'd1:    samp_r[1] <= sync2_r;
                default: samp_r    <= samp_r;
            endcase
        end else begin
            samp_cnt_r <= 2'd0;
            samp_r     <= samp_r;
        end
    end

    // Decision register and its one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            comp_out_r   <= 1'b0;
            comp_valid_r <= 1'b0;
        end else if (sample_done_s) begin
            comp_out_r   <= maj3(samp_r[0], samp_r[1], sync2_r);
            comp_valid_r <= 1'b1;
        end else begin
            comp_out_r   <= comp_out_r;
            comp_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_pwm_dac.sv
// Self-checking bench for sar_pwm_dac: random trials against a timing/majority
// reference model, with a scoreboard monitor checking each decision pulse.
module tb_sar_pwm_dac;

    localparam int N   = 4;
    localparam int A   = N * 256;     // edge (relative to accept) entering SAMPLE
    localparam int LAT = A + 3;       // edge at which the decision is presented

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] code_in;
    logic       code_valid;
    logic       code_ready;
    logic       comp_in;
    logic       pwm_out;
    logic       comp_out;
    logic       comp_valid;
    logic       busy;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic exp_q[$];
    int   edge_q[$];

    sar_pwm_dac #(.SETTLE_PERIODS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .comp_in    (comp_in),
        .pwm_out    (pwm_out),
        .comp_out   (comp_out),
        .comp_valid (comp_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor: every decision pulse pops one expectation.
    always @(negedge clk) begin
        if (!rst && comp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_comp_valid", 1, 0);
            end else begin
                chk("comp_out", int'(comp_out), int'(exp_q.pop_front()));
                chk("decision_edge", cyc, edge_q.pop_front());
            end
        end
    end

    function automatic logic ref_decision(input logic [2:0] pat);
        int ones;
        ones = int'(pat[0]) + int'(pat[1]) + int'(pat[2]);
        return (ones >= 2);
    endfunction

    // One full trial; entered and left #1 after a rising edge.
    task automatic trial(input logic [7:0] code, input logic [2:0] pat,
                         input bit zero_bg, input bit junk, input int gap);
        int e0;
        int hi;
        for (int g = 0; g < gap; g++) begin
            code_valid = 1'b0;
            comp_in    = zero_bg ? 1'b0 : 1'($urandom);
            @(negedge clk);
            chk("ready_idle", int'(code_ready), 1);
            @(posedge clk); #1;
        end
        code_in    = code;
        code_valid = 1'b1;
        comp_in    = zero_bg ? 1'b0 : 1'($urandom);
        @(negedge clk);
        chk("ready_before_accept", int'(code_ready), 1);
        @(posedge clk); #1;
        e0 = cyc;
        exp_q.push_back(ref_decision(pat));
        edge_q.push_back(e0 + LAT);
        code_valid = 1'b0;
        code_in    = 8'($urandom);
        hi = 0;
        for (int rel = 1; rel <= LAT; rel++) begin
            if (junk && rel >= 2 && rel <= 600) begin
                code_valid = 1'b1;
                code_in    = 8'h40;
            end else begin
                code_valid = 1'b0;
            end
            if (rel == A - 1)      comp_in = pat[0];
            else if (rel == A)     comp_in = pat[1];
            else if (rel == A + 1) comp_in = pat[2];
            else                   comp_in = zero_bg ? 1'b0 : 1'($urandom);
            @(negedge clk);
            if (rel >= 2 && rel <= 257) hi += int'(pwm_out);
            if (rel == 2) begin
                chk("busy_settle", int'(busy), 1);
                chk("ready_settle", int'(code_ready), 0);
            end
            @(posedge clk); #1;
        end
        code_valid = 1'b0;
        chk("pwm_duty", hi, int'(code));
    endtask

    // Accept a code, then reset at relative edge 500.
    task automatic mid_reset(input logic [7:0] code);
        code_in    = code;
        code_valid = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(1'b0);
        edge_q.push_back(cyc + LAT);
        code_valid = 1'b0;
        for (int rel = 1; rel <= 500; rel++) begin
            comp_in = 1'b1;
            if (rel == 500) rst = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        void'(exp_q.pop_back());
        void'(edge_q.pop_back());
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_comp_valid", int'(comp_valid), 0);
        chk("midrst_comp_out", int'(comp_out), 0);
        chk("midrst_pwm", int'(pwm_out), 0);
        chk("midrst_ready", int'(code_ready), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        code_valid = 1'b1;
        code_in    = 8'h5A;
        comp_in    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_pwm", int'(pwm_out), 0);
            chk("rst_comp_out", int'(comp_out), 0);
            chk("rst_comp_valid", int'(comp_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_ready", int'(code_ready), 0);
        end
        @(posedge clk); #1;
        rst        = 1'b0;
        code_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", int'(code_ready), 1);
        chk("post_rst_busy", int'(busy), 0);
        @(posedge clk); #1;

        trial(8'h80, 3'b111, 1'b0, 1'b0, 0);   // mid-scale, decision 1
        trial(8'h00, 3'b000, 1'b0, 1'b0, 0);   // never high, back-to-back
        trial(8'hFF, 3'b111, 1'b0, 1'b0, 2);   // low one cycle per period
        trial(8'h55, 3'b010, 1'b1, 1'b0, 0);   // single-sample glitch rejected
        trial(8'h33, 3'b011, 1'b1, 1'b0, 0);   // two-sample high wins
        trial(8'h9A, 3'b110, 1'b1, 1'b0, 1);
        trial(8'h20, 3'b111, 1'b0, 1'b1, 0);   // 0x40 offered while busy
        mid_reset(8'hC3);
        trial(8'h77, 3'b101, 1'b0, 1'b0, 0);   // full latency after abort
        for (int t = 0; t < 4; t++) begin
            trial(8'($urandom), 3'($urandom), 1'b0, 1'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sar_pwm_dac.md
# sar_pwm_dac

Digital back end of the SAR converter's analog loop: accepts each 8-bit trial code from the SAR controller, renders it as a PWM waveform for the external RC-filtered DAC, waits a fixed settling interval, then samples the external comparator and returns one decision bit. It is the responder on the SAR's trial-code/decision interface. It replaces the bench-driven comparator bit with a real sequenced DAC and comparator front end.

## Interface

Parameters:
- SETTLE_PERIODS, 4: full 256-cycle PWM periods to wait before sampling; legal range 1..16.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- code_in  in  8  trial code from the SAR controller.
- code_valid  in  1  trial code offered.
- code_ready  out  1  block can accept a code; high only in IDLE and not in reset.
- comp_in  in  1  raw external comparator output, asynchronous to clk.
- pwm_out  out  1  registered PWM drive to the external RC filter.
- comp_out  out  1  comparator decision for the last accepted code; held until the next decision.
- comp_valid  out  1  one-cycle pulse marking a new comp_out.
- busy  out  1  high in SETTLE or SAMPLE.

## Operation

- States: IDLE, SETTLE, SAMPLE.
- IDLE:
  - code_ready=1.
  - A handshake (code_valid & code_ready at a clk edge) latches code_in into code_reg, clears pwm_cnt and the period counter, and moves to SETTLE.
- SETTLE:
  - pwm_cnt (8-bit) increments every cycle and wraps 255 to 0.
  - The period counter (4-bit) increments on each wrap.
  - When period counter = SETTLE_PERIODS-1 and pwm_cnt = 255, go to SAMPLE.
- SAMPLE:
  - Lasts exactly 3 cycles; captures the synchronized comparator bit each cycle.
  - On the 3rd cycle, register comp_out as the majority of the 3 samples, pulse comp_valid, and return to IDLE.
- PWM:
  - pwm_out is registered: pwm_out <= (pwm_cnt < code_reg), an unsigned 8-bit compare.
  - Duty = code/256. Code 0x00 never drives high; code 0xFF drives low only when pwm_cnt = 255.
  - In IDLE, pwm_cnt keeps free-running with the held code_reg so the filter stays near the last trial level.
- Comparator input: comp_in passes through a 2-flop synchronizer that is always running. Samples use the 2nd flop.
- code_valid is ignored while busy. code_in is not required to stay stable after acceptance.

## Timing

- Reset (rst high at an edge):
  - State goes to IDLE; code_reg, pwm_cnt, period counter, synchronizer flops, comp_out, comp_valid and pwm_out go to 0.
  - code_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Latency, with the accept edge numbered 0 and N = SETTLE_PERIODS:
  - Edges 1..N*256: SETTLE. pwm_cnt is 0 in the cycle after edge 0, so pwm_out reflects the new code from the cycle after edge 1.
  - Edge N*256: state goes to SAMPLE.
  - Edges N*256+1, +2, +3: samples captured.
  - Edge N*256+3: comp_out updated, comp_valid=1 for one cycle, state IDLE, busy=0, code_ready=1.
  - Default N=4: comp_valid is high in the cycle after edge 1027.
- Synchronizer adds 2 cycles. comp_in must be stable from edge N*256-1 onward to be counted in all 3 samples.
- Back-to-back: a code offered while comp_valid is high is accepted at that same edge (edge N*256+4). Throughput is one decision per N*256+4 cycles.
- Reset mid-operation: at the next edge the block is in IDLE with no comp_valid pulse. comp_out returns to 0 and the in-flight code is dropped.
- Simultaneous rst and code_valid: rst wins; nothing is accepted.

## Test plan

- Reset: hold rst 3 cycles with code_valid=1 -> pwm_out, comp_out, comp_valid, busy all 0; code_ready 0 during reset and 1 the cycle after release; no acceptance.
- Mid-scale: code 0x80, comp_in=1, N=4 -> pwm_out high exactly 128 of every 256 cycles; busy high from edge 1; single comp_valid pulse after edge 1027 with comp_out=1.
- Extremes: code 0x00 -> pwm_out stays 0 over a full period; code 0xFF -> pwm_out low only 1 cycle per 256.
- Glitch rejection: comp_in=0 except a 1-cycle high landing on exactly one of the 3 samples -> comp_out=0. A 2-sample-wide high -> comp_out=1.
- Protocol:
  - code 0x40 offered during SETTLE -> ignored, code_ready=0, duty stays that of the original code.
  - Same code held through comp_valid -> accepted at that edge; next decision is 1028 cycles later.
- Reset mid-SETTLE at cycle 500 -> IDLE next cycle, no comp_valid, comp_out 0; a new code is accepted afterward with full latency.
